// File: rtl/idv_osc_meas_ctl.sv
// Measurement controller for an IDV ring-oscillator bank: wakes the bank, enables one
// oscillator, and counts synchronised hfbankl rising edges over a programmed window.
module idv_osc_meas_ctl #(
   parameter int unsigned NOSC       = 63,
   parameter int unsigned CNT_W      = 20,
   parameter int unsigned WIN_W      = 16,
   parameter int unsigned WAKE_CYC   = 8,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic             idvdebug_clki,
   input  logic             idvdebug_rst_b,
   input  logic             start,
   input  logic             abort,
   input  logic [5:0]       osc_sel,
   input  logic [WIN_W-1:0] win_len,
   input  logic             hfbankl,
   output logic [NOSC:1]    enosc,
   output logic             sleep_b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic             ovf,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAKE,
      S_SETTLE,
      S_MEASURE,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_nxt;
   logic [WIN_W-1:0]   r_tmr;
   logic [WIN_W-1:0]   w_tmr_nxt;
   logic [5:0]         r_sel;
   logic [WIN_W-1:0]   r_win;
   logic               r_s1, r_s2, r_s3;
   logic               w_edge;
   logic [CNT_W-1:0]   r_ecnt;
   logic [CNT_W-1:0]   w_ecnt_nxt;
   logic               r_ovf_flag;
   logic               w_ovf_nxt;
   logic               w_start_ok;
   logic               w_start_bad;
   logic [NOSC:1]      w_onehot;
   logic [NOSC:1]      r_enosc;
   logic               r_sleep_b;
   logic               r_busy;
   logic               r_done;
   logic [CNT_W-1:0]   r_result;
   logic               r_ovf;
   logic               r_err;

   assign w_edge      = r_s2 & ~r_s3;
   assign w_start_ok  = start && (osc_sel != '0) && (32'(osc_sel) <= NOSC) && (win_len != '0);
   assign w_start_bad = start && !w_start_ok;

   always_comb begin
      w_onehot = '0;
      for (int unsigned i = 1; i <= NOSC; i++) begin
         w_onehot[i] = (32'(r_sel) == i);
      end
   end

   always_ff @(posedge idvdebug_clki) begin
      if (!idvdebug_rst_b) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_nxt;
         r_tmr   <= w_tmr_nxt;
      end
   end

   // Timer is reloaded on each phase entry; a phase lasts (reload value + 1) cycles.
   always_comb begin
      w_nxt     = r_state;
      w_tmr_nxt = r_tmr;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_nxt     = S_WAKE;
               w_tmr_nxt = WIN_W'(WAKE_CYC - 1);
            end
         end
         S_WAKE: begin
            if (abort) begin
               w_nxt = S_IDLE;
            end else if (r_tmr == '0) begin
               w_nxt     = S_SETTLE;
               w_tmr_nxt = WIN_W'(SETTLE_CYC - 1);
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               w_nxt = S_IDLE;
            end else if (r_tmr == '0) begin
               w_nxt     = S_MEASURE;
               w_tmr_nxt = r_win - 1'b1;
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         S_MEASURE: begin
            if (abort) begin
               w_nxt = S_IDLE;
            end else if (r_tmr == '0) begin
               w_nxt = S_DONE;
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_ecnt_nxt = r_ecnt;
      w_ovf_nxt  = r_ovf_flag;
      if (r_state == S_MEASURE && w_edge) begin
         if (r_ecnt == '1) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_ecnt_nxt = r_ecnt + 1'b1;
         end
      end
   end

   always_ff @(posedge idvdebug_clki) begin
      if (!idvdebug_rst_b) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_ecnt     <= '0;
         r_ovf_flag <= 1'b0;
         r_sel      <= '0;
         r_win      <= '0;
      end else begin
         r_s1 <= hfbankl;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (r_state == S_SETTLE) begin
            r_ecnt     <= '0;
            r_ovf_flag <= 1'b0;
         end else begin
            r_ecnt     <= w_ecnt_nxt;
            r_ovf_flag <= w_ovf_nxt;
         end
         if (r_state == S_IDLE && w_start_ok) begin
            r_sel <= osc_sel;
            r_win <= win_len;
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge idvdebug_clki) begin
      if (!idvdebug_rst_b) begin
         r_enosc   <= '0;
         r_sleep_b <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_busy    <= (w_nxt != S_IDLE);
         r_sleep_b <= (w_nxt == S_WAKE) || (w_nxt == S_SETTLE) || (w_nxt == S_MEASURE);
         r_enosc   <= ((w_nxt == S_SETTLE) || (w_nxt == S_MEASURE)) ? w_onehot : '0;
         r_done    <= (r_state == S_MEASURE) && (w_nxt == S_DONE);
         if (r_state == S_MEASURE && w_nxt == S_DONE) begin
            r_result <= w_ecnt_nxt;
            r_ovf    <= w_ovf_nxt;
         end
         if (r_state == S_IDLE) begin
            if (w_start_bad) begin
               r_err <= 1'b1;
            end else if (w_start_ok) begin
               r_err <= 1'b0;
            end
         end
      end
   end

   assign enosc   = r_enosc;
   assign sleep_b = r_sleep_b;
   assign busy    = r_busy;
   assign done    = r_done;
   assign result  = r_result;
   assign ovf     = r_ovf;
   assign err     = r_err;

endmodule

// File: tb/tb_idv_osc_meas_ctl.sv
// Directed bench for idv_osc_meas_ctl: timing of wake/settle/measure, edge counting,
// rejected starts, abort, busy-start, reset mid-run and counter saturation.
module tb_idv_osc_meas_ctl;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          start, start4, abort;
   logic [5:0]    osc_sel;
   logic [15:0]   win_len;
   logic          hf = 1'b0;
   int            hf_div = 0;

   logic [63:1]   enosc, enosc4;
   logic          sleep_b, busy, done, ovf, err;
   logic          sleep_b4, busy4, done4, ovf4, err4;
   logic [19:0]   result;
   logic [3:0]    result4;

   int            errors = 0;
   int            checks = 0;
   int            cyc;
   int            n_done;
   int            first_done;
   logic [63:1]   exp_en;

   idv_osc_meas_ctl u_dut (
      .idvdebug_clki(clk), .idvdebug_rst_b(rst_b), .start(start), .abort(abort),
      .osc_sel(osc_sel), .win_len(win_len), .hfbankl(hf),
      .enosc(enosc), .sleep_b(sleep_b), .busy(busy), .done(done),
      .result(result), .ovf(ovf), .err(err)
   );

   idv_osc_meas_ctl #(.CNT_W(4)) u_dut4 (
      .idvdebug_clki(clk), .idvdebug_rst_b(rst_b), .start(start4), .abort(abort),
      .osc_sel(osc_sel), .win_len(win_len), .hfbankl(hf),
      .enosc(enosc4), .sleep_b(sleep_b4), .busy(busy4), .done(done4),
      .result(result4), .ovf(ovf4), .err(err4)
   );

   always #5 clk = ~clk;

   // Oscillator model: period = hf_div clocks, transitions offset from clock edges.
   initial begin
      #3;
      forever begin
         if (hf_div == 0) begin
            hf = 1'b0;
            #10;
         end else begin
            #(hf_div * 5);
            hf = ~hf;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to_done(input int max_cyc);
      n_done     = 0;
      first_done = -1;
      while (cyc < max_cyc) begin
         tick();
         if (done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = cyc;
         end
      end
   endtask

   initial begin
      rst_b = 1'b0; start = 1'b0; start4 = 1'b0; abort = 1'b0;
      osc_sel = '0; win_len = '0; cyc = 0;
      repeat (3) tick();
      chk("rst_enosc", 64'(enosc), 64'd0);
      chk("rst_sleep", 64'(sleep_b), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_ovf_err", 64'({ovf, err}), 64'd0);
      rst_b = 1'b1;
      tick();

      // Nominal: osc 5, window 100, hfbankl = clk/4
      hf_div = 4;
      repeat (4) tick();
      osc_sel = 6'd5; win_len = 16'd100; start = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0;
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_sleep_wake", 64'(sleep_b), 64'd1);
      chk("t1_enosc_wake", 64'(enosc), 64'd0);
      while (cyc < 8) tick();
      chk("t1_enosc_c8", 64'(enosc), 64'd0);
      tick();
      exp_en = '0; exp_en[5] = 1'b1;
      chk("t1_enosc_c9", 64'(enosc), 64'(exp_en));
      run_to_done(140);
      chk("t1_done_cycle", 64'(first_done), 64'd125);
      chk("t1_done_count", 64'(n_done), 64'd1);
      chk("t1_result", 64'(result), 64'd25);
      chk("t1_ovf", 64'(ovf), 64'd0);
      chk("t1_idle_busy", 64'(busy), 64'd0);
      chk("t1_idle_enosc", 64'(enosc), 64'd0);

      // Rejected starts set err and keep the block idle
      osc_sel = 6'd0; win_len = 16'd10; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_err_sel0", 64'(err), 64'd1);
      chk("t2_busy_sel0", 64'(busy), 64'd0);
      chk("t2_enosc_sel0", 64'(enosc), 64'd0);
      repeat (3) tick();
      chk("t2_err_held", 64'(err), 64'd1);
      osc_sel = 6'd3; win_len = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_err_win0", 64'(err), 64'd1);
      chk("t2_busy_win0", 64'(busy), 64'd0);

      // Valid start on osc 63 clears err; a start mid-MEASURE is ignored
      osc_sel = 6'd63; win_len = 16'd20; start = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0;
      chk("t3_err_clr", 64'(err), 64'd0);
      chk("t3_busy", 64'(busy), 64'd1);
      while (cyc < 10) tick();
      exp_en = '0; exp_en[63] = 1'b1;
      chk("t3_enosc63", 64'(enosc), 64'(exp_en));
      while (cyc < 30) tick();
      osc_sel = 6'd7; win_len = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t3_enosc_keep", 64'(enosc), 64'(exp_en));
      chk("t3_err_busy_start", 64'(err), 64'd0);
      run_to_done(80);
      chk("t3_done_cycle", 64'(first_done), 64'd45);
      chk("t3_done_count", 64'(n_done), 64'd1);
      chk("t3_result", 64'(result), 64'd5);

      // Abort on the 10th MEASURE cycle (cycle 34)
      osc_sel = 6'd2; win_len = 16'd100; start = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0;
      while (cyc < 34) tick();
      chk("t4_measuring", 64'(sleep_b), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_sleep", 64'(sleep_b), 64'd0);
      chk("t4_enosc", 64'(enosc), 64'd0);
      run_to_done(200);
      chk("t4_no_done", 64'(n_done), 64'd0);
      chk("t4_result_kept", 64'(result), 64'd5);

      // Reset during SETTLE, then a fresh start (with abort in the same cycle)
      osc_sel = 6'd9; win_len = 16'd8; start = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0;
      while (cyc < 12) tick();
      rst_b = 1'b0;
      tick();
      chk("t5_rst_enosc", 64'(enosc), 64'd0);
      chk("t5_rst_flags", 64'({sleep_b, busy, done, ovf, err}), 64'd0);
      chk("t5_rst_result", 64'(result), 64'd0);
      rst_b = 1'b1;
      tick();
      start = 1'b1; abort = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("t5_start_wins", 64'(busy), 64'd1);
      run_to_done(50);
      chk("t5_done_cycle", 64'(first_done), 64'd33);
      chk("t5_result", 64'(result), 64'd2);

      // 4-bit counter saturates with hfbankl = clk/2 over 64 cycles
      hf_div = 2;
      osc_sel = 6'd1; win_len = 16'd64; start4 = 1'b1;
      cyc = 0;
      tick();
      start4 = 1'b0;
      chk("t6_busy4", 64'(busy4), 64'd1);
      while (cyc < 89 && done4 !== 1'b1) tick();
      chk("t6_done4_cycle", 64'(cyc), 64'd89);
      chk("t6_done4", 64'(done4), 64'd1);
      chk("t6_result4", 64'(result4), 64'd15);
      chk("t6_ovf4", 64'(ovf4), 64'd1);
      chk("t6_main_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
